// File: rtl/vga_timing.sv
// Raster timing generator: free-running H/V counters gated by CLKEN, producing
// sync, display-enable, position, end-of-line/frame strobes and a line interrupt.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          PIXELCLK,
  input  logic          nRESET,
  input  logic          CLKEN,
  input  logic [VW-1:0] LINE_CMP,
  output logic          VGA_HSYNC,
  output logic          VGA_VSYNC,
  output logic          DISEN,
  output logic [HW-1:0] H_POS,
  output logic [VW-1:0] V_POS,
  output logic          ENDofLINE,
  output logic          NEWSCREEN,
  output logic          LINE_IRQ
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        HW < 1 || VW < 1 ||
        longint'(HTOTAL - 1) >= (longint'(1) << HW) ||
        longint'(VTOTAL - 1) >= (longint'(1) << VW)) begin : g_param_check
      $error("vga_timing: illegal timing parameters or counter widths");
    end
  endgenerate

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_reg, h_next;
  logic [VW-1:0] v_reg, v_next;
  logic          h_wrap;
  logic          disen_reg, hsync_reg, vsync_reg, irq_reg;

  assign h_wrap = (h_reg == H_LAST);
  assign h_next = h_wrap ? '0 : h_reg + HW'(1);
  assign v_next = !h_wrap ? v_reg : ((v_reg == V_LAST) ? '0 : v_reg + VW'(1));

  // Registered outputs are computed from the next counts so they line up with H_POS/V_POS.
  always_ff @(posedge PIXELCLK or negedge nRESET) begin
    if (!nRESET) begin
      h_reg     <= H_LAST;
      v_reg     <= V_LAST;
      disen_reg <= 1'b0;
      hsync_reg <= ~HS_POL;
      vsync_reg <= ~VS_POL;
      irq_reg   <= 1'b0;
    end else if (CLKEN) begin
      h_reg     <= h_next;
      v_reg     <= v_next;
      disen_reg <= (h_next < H_VIS) && (v_next < V_VIS);
      hsync_reg <= (h_next >= HS_BEGIN && h_next < HS_END) ? HS_POL : ~HS_POL;
      vsync_reg <= (v_next >= VS_BEGIN && v_next < VS_END) ? VS_POL : ~VS_POL;
      irq_reg   <= h_wrap && (v_next == LINE_CMP);
    end else begin
      irq_reg   <= 1'b0;
    end
  end

  assign H_POS     = h_reg;
  assign V_POS     = v_reg;
  assign DISEN     = disen_reg;
  assign VGA_HSYNC = hsync_reg;
  assign VGA_VSYNC = vsync_reg;
  assign LINE_IRQ  = irq_reg;
  assign ENDofLINE = CLKEN & h_wrap & nRESET;
  assign NEWSCREEN = ENDofLINE & (v_reg == V_LAST);

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing on a tiny 14x7 raster (H 8/2/2/2, V 4/1/1/1, HSYNC active-high).
module tb_vga_timing;

  logic       clk;
  logic       nRESET;
  logic       CLKEN;
  logic [2:0] LINE_CMP;
  logic       VGA_HSYNC, VGA_VSYNC, DISEN, ENDofLINE, NEWSCREEN, LINE_IRQ;
  logic [3:0] H_POS;
  logic [2:0] V_POS;

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .HW(4), .VW(3)
  ) dut (
    .PIXELCLK (clk),
    .nRESET   (nRESET),
    .CLKEN    (CLKEN),
    .LINE_CMP (LINE_CMP),
    .VGA_HSYNC(VGA_HSYNC),
    .VGA_VSYNC(VGA_VSYNC),
    .DISEN    (DISEN),
    .H_POS    (H_POS),
    .V_POS    (V_POS),
    .ENDofLINE(ENDofLINE),
    .NEWSCREEN(NEWSCREEN),
    .LINE_IRQ (LINE_IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h;
    logic [2:0] v;
    logic       de, hs, vs, eol, ns, irq;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Expected raster position as seen between edges; HTOTAL=14, VTOTAL=7.
  int eh   = 13;
  int ev   = 6;
  bit eirq = 1'b0;

  task automatic step(input bit ce, input int cmp, input bit rn);
    exp_t e;
    @(negedge clk);
    CLKEN    = ce;
    LINE_CMP = 3'(cmp);
    nRESET   = rn;
    if (!rn) begin
      eh = 13; ev = 6; eirq = 1'b0;
    end
    e.h   = 4'(eh);
    e.v   = 3'(ev);
    e.de  = (eh < 8) && (ev < 4);
    e.hs  = (eh == 10) || (eh == 11);
    e.vs  = (ev != 5);
    e.eol = ce && rn && (eh == 13);
    e.ns  = e.eol && (ev == 6);
    e.irq = eirq;
    q.push_back(e);
    if (rn && ce) begin
      if (eh == 13) begin
        eh   = 0;
        ev   = (ev == 6) ? 0 : ev + 1;
        eirq = (ev == cmp);
      end else begin
        eh   = eh + 1;
        eirq = 1'b0;
      end
    end else begin
      eirq = 1'b0;
    end
  endtask

  exp_t        m;
  logic [12:0] got, want;
  always @(negedge clk) begin
    #1;
    if (q.size() > 0) begin
      m    = q.pop_front();
      got  = {H_POS, V_POS, DISEN, VGA_HSYNC, VGA_VSYNC, ENDofLINE, NEWSCREEN, LINE_IRQ};
      want = {m.h, m.v, m.de, m.hs, m.vs, m.eol, m.ns, m.irq};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL vec%0d: got h=%0d v=%0d de=%b hs=%b vs=%b eol=%b ns=%b irq=%b, want h=%0d v=%0d de=%b hs=%b vs=%b eol=%b ns=%b irq=%b",
                 vectors, H_POS, V_POS, DISEN, VGA_HSYNC, VGA_VSYNC, ENDofLINE, NEWSCREEN, LINE_IRQ,
                 m.h, m.v, m.de, m.hs, m.vs, m.eol, m.ns, m.irq);
      end else begin
        $display("vec%0d ok: h=%0d v=%0d de=%b hs=%b vs=%b eol=%b ns=%b irq=%b ce=%b rst_n=%b",
                 vectors, H_POS, V_POS, DISEN, VGA_HSYNC, VGA_VSYNC, ENDofLINE, NEWSCREEN, LINE_IRQ,
                 CLKEN, nRESET);
      end
    end
  end

  initial begin
    nRESET   = 1'b0;
    CLKEN    = 1'b1;
    LINE_CMP = 3'd2;

    // Reset held with CLKEN high: strobes must stay low even though H sits at its last value.
    for (int i = 0; i < 3; i++) step(1'b1, 2, 1'b0);
    // Two full frames at full rate, interrupt on line 2.
    for (int i = 0; i < 196; i++) step(1'b1, 2, 1'b1);
    // Half-rate advance: outputs hold and strobes drop on the idle cycles.
    for (int i = 0; i < 392; i++) step(i[0] == 1'b0, 3, 1'b1);
    // Compare value beyond the last line never fires; line 0 fires at frame start.
    for (int i = 0; i < 196; i++) step(1'b1, 7, 1'b1);
    for (int i = 0; i < 98; i++) step(1'b1, 0, 1'b1);
    // Compare value changed mid-line takes effect at the next wrap.
    for (int i = 0; i < 196; i++) step(1'b1, (i < 40) ? 1 : 5, 1'b1);
    // Reset dropped between edges in mid-frame, then released.
    for (int i = 0; i < 37; i++) step(1'b1, 4, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 4, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 0, 1'b1);
    // Irregular enable pattern with varying compare values.
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1);

    @(negedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
